// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, no parity, one stop bit.
// Centre-samples each bit and strobes valid or framing-error for one clock.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ce_16,
    input  logic                 ser_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 new_rx_data,
    output logic                 frame_err,
    output logic                 rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

    state_t               state;
    logic [3:0]           tick;
    logic [2:0]           bitcnt;
    logic [DATA_BITS-1:0] shift;
    logic                 sync1;
    logic                 in_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            in_s  <= 1'b1;
        end else begin
            sync1 <= ser_in;
            in_s  <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tick        <= 4'd0;
            bitcnt      <= 3'd0;
            shift       <= '0;
            rx_data     <= '0;
            new_rx_data <= 1'b0;
            frame_err   <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            // strobes self-clear so they last one clock whatever the ce_16 spacing
            new_rx_data <= 1'b0;
            frame_err   <= 1'b0;
            if (ce_16) begin
                unique case (state)
                    IDLE: begin
                        if (!in_s) begin
                            state   <= START;
                            tick    <= 4'd0;
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        tick <= tick + 4'd1;
                        if (tick == 4'd7) begin
                            if (!in_s) begin
                                state  <= DATA;
                                tick   <= 4'd0;
                                bitcnt <= 3'd0;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        tick <= tick + 4'd1;
                        if (tick == 4'd15) begin
                            shift  <= {in_s, shift[DATA_BITS-1:1]};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == LAST) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        tick <= tick + 4'd1;
                        if (tick == 4'd15) begin
                            rx_data <= shift;
                            if (in_s) begin
                                new_rx_data <= 1'b1;
                                state       <= IDLE;
                                rx_busy     <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        // wait for the line to go idle so a held-low line is one error
                        if (in_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8-bit and 5-bit receivers on shared clock/ce.
// Monitors count strobes at the falling edge; all checks go through check().
module tb_uart_rx;

    logic       clock;
    logic       reset;
    logic       ce_16;
    logic       ser_in8;
    logic       ser_in5;
    logic [7:0] rx8;
    logic [4:0] rx5;
    logic       nrx8;
    logic       ferr8;
    logic       busy8;
    logic       nrx5;
    logic       ferr5;
    logic       busy5;

    int checks   = 0;
    int failures = 0;
    int ce_div   = 1;
    int ce_cnt   = 0;
    int cyc      = 0;

    int         n8       = 0;
    int         f8       = 0;
    int         n5       = 0;
    int         f5       = 0;
    int         wide8    = 0;
    int         both8    = 0;
    logic       prev8    = 1'b0;
    logic [7:0] log8[16];
    logic [7:0] ferr_dat = 8'h00;
    int         strobe_cyc8 = 0;
    int         strobe_cyc5 = 0;
    int         start_cyc   = 0;

    uart_rx #(.DATA_BITS(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .ce_16       (ce_16),
        .ser_in      (ser_in8),
        .rx_data     (rx8),
        .new_rx_data (nrx8),
        .frame_err   (ferr8),
        .rx_busy     (busy8)
    );

    uart_rx #(.DATA_BITS(5)) dut5 (
        .clock       (clock),
        .reset       (reset),
        .ce_16       (ce_16),
        .ser_in      (ser_in5),
        .rx_data     (rx5),
        .new_rx_data (nrx5),
        .frame_err   (ferr5),
        .rx_busy     (busy5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        ce_16 = (ce_cnt == 0);
        ce_cnt = (ce_cnt + 1 >= ce_div) ? 0 : ce_cnt + 1;
    end

    always @(negedge clock) begin
        if (nrx8) begin
            if (n8 < 16) log8[n8] = rx8;
            n8++;
            strobe_cyc8 = cyc;
        end
        if (ferr8) begin
            f8++;
            ferr_dat = rx8;
        end
        if (nrx8 && prev8) wide8++;
        if (nrx8 && ferr8) both8++;
        prev8 = nrx8;
        if (nrx5) begin
            n5++;
            strobe_cyc5 = cyc;
        end
        if (ferr5) f5++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) ser_in8 = v;
        else ser_in5 = v;
    endtask

    task automatic send(input int which, input logic [7:0] d,
                        input int nbits, input logic stop);
        int bt;
        bt = 16 * ce_div;
        @(negedge clock);
        drive(which, 1'b0);
        start_cyc = cyc;
        repeat (bt) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            drive(which, d[i]);
            repeat (bt) @(negedge clock);
        end
        drive(which, stop);
        repeat (bt) @(negedge clock);
    endtask

    initial begin
        int n0;
        logic [7:0] dff;
        reset   = 1'b0;
        ser_in8 = 1'b1;
        ser_in5 = 1'b1;
        ce_16   = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_rx_data", 32'(rx8), 32'h00);
        check("rst_busy", 32'(busy8), 32'h0);
        check("rst_strobes", 32'({nrx8, ferr8}), 32'h0);
        reset = 1'b1;
        repeat (20) @(negedge clock);

        // 1: 0xA5, ce every clock
        send(0, 8'hA5, 8, 1'b1);
        repeat (16) @(negedge clock);
        check("t1_count", 32'(n8), 32'd1);
        check("t1_data", 32'(rx8), 32'hA5);
        check("t1_ferr", 32'(f8), 32'd0);
        check("t1_busy", 32'(busy8), 32'h0);
        check("t1_latency", 32'(strobe_cyc8 - start_cyc), 32'd155);

        // 2: ce every 3 clocks, back-to-back frames
        ce_div = 3;
        repeat (10) @(negedge clock);
        send(0, 8'h3C, 8, 1'b1);
        send(0, 8'hC3, 8, 1'b1);
        repeat (96) @(negedge clock);
        check("t2_count", 32'(n8), 32'd3);
        check("t2_first", 32'(log8[1]), 32'h3C);
        check("t2_second", 32'(log8[2]), 32'hC3);
        check("t2_width", 32'(wide8), 32'd0);

        // 3: 4-tick glitch rejected
        ce_div = 1;
        repeat (10) @(negedge clock);
        ser_in8 = 1'b0;
        repeat (4) @(negedge clock);
        ser_in8 = 1'b1;
        repeat (2) @(negedge clock);
        check("t3_busy_hi", 32'(busy8), 32'h1);
        repeat (20) @(negedge clock);
        check("t3_busy_lo", 32'(busy8), 32'h0);
        check("t3_no_strobe", 32'(n8 + f8), 32'd3);
        check("t3_data", 32'(rx8), 32'hC3);

        // 4: framing error, long break, recovery
        send(0, 8'h55, 8, 1'b0);
        repeat (40 * 16) @(negedge clock);
        check("t4_ferr", 32'(f8), 32'd1);
        check("t4_ferr_data", 32'(ferr_dat), 32'h55);
        check("t4_break_busy", 32'(busy8), 32'h1);
        check("t4_no_nrx", 32'(n8), 32'd3);
        ser_in8 = 1'b1;
        repeat (32) @(negedge clock);
        check("t4_idle", 32'(busy8), 32'h0);
        send(0, 8'h0F, 8, 1'b1);
        repeat (16) @(negedge clock);
        check("t4_count", 32'(n8), 32'd4);
        check("t4_data", 32'(rx8), 32'h0F);
        check("t4_ferr_once", 32'(f8), 32'd1);

        // 5: reset mid data bit 4 of 0xFF
        dff = 8'hFF;
        n0 = n8;
        @(negedge clock);
        ser_in8 = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            ser_in8 = dff[i];
            repeat (16) @(negedge clock);
        end
        ser_in8 = dff[4];
        repeat (8) @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5_rst_data", 32'(rx8), 32'h00);
        check("t5_rst_busy", 32'(busy8), 32'h0);
        check("t5_rst_strobe", 32'({nrx8, ferr8}), 32'h0);
        @(negedge clock);
        ser_in8 = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (200) @(negedge clock);
        check("t5_no_strobe", 32'(n8 - n0), 32'd0);
        check("t5_data_zero", 32'(rx8), 32'h00);
        send(0, 8'h81, 8, 1'b1);
        repeat (16) @(negedge clock);
        check("t5_count", 32'(n8 - n0), 32'd1);
        check("t5_data", 32'(rx8), 32'h81);

        // 6: 5-bit receiver
        send(1, 8'h1B, 5, 1'b1);
        repeat (16) @(negedge clock);
        check("t6_count", 32'(n5), 32'd1);
        check("t6_data", 32'(rx5), 32'h1B);
        check("t6_ferr", 32'(f5), 32'd0);
        check("t6_latency", 32'(strobe_cyc5 - start_cyc), 32'd107);
        check("never_both", 32'(both8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
